pipe_reg_file: RTL and testbench

- Parametrised register file for the pipelined RV32I core; successor to the single-cycle core's 32x32 file.
- Provides 2 async read ports, 1 sync write port, optional write-to-read bypass and a per-register pending scoreboard for hazard detection.
- Reset is a sequential clear sweep, one entry per cycle, so the array can map to distributed/block RAM without a parallel reset.
- Sits between decode (reads, issue marking) and writeback (write, pending clear).

---
 rtl/rv_pkg.sv | 13 +
 rtl/reg_scoreboard.sv | 52 +++++
 rtl/pipe_reg_file.sv | 121 ++++++++++++
 tb/tb_pipe_reg_file.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared definitions for the RV32I pipelined core register file:
// default data width, the hardwired-zero register index and the sweep FSM encoding.
package rv_pkg;

    localparam int XLEN_DEF = 32;
    localparam int REG_ZERO = 0;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } rf_state_e;

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register pending bits for hazard detection: issue marks a destination
// outstanding, writeback retires it, and each read port gets a busy lookup.
module reg_scoreboard
    import rv_pkg::*;
#(
    parameter  int NREG     = 32,
    parameter  int BYPASS   = 1,
    parameter  int ZERO_REG = 1,
    localparam int AW       = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic          issue_en,
    input  logic [AW-1:0] issue_addr,
    input  logic [AW-1:0] rs1_addr,
    input  logic [AW-1:0] rs2_addr,
    output logic          rs1_busy,
    output logic          rs2_busy
);

    logic [NREG-1:0] pending_q;
    logic [NREG-1:0] pending_d;

    // Set beats clear on the same entry: the newly issued producer is still outstanding.
    for (genvar gi = 0; gi < NREG; gi++) begin : g_pend
        localparam bit CAN_PEND = !((ZERO_REG != 0) && (gi == REG_ZERO));
        logic set_hit;
        logic clr_hit;
        assign set_hit = CAN_PEND && en && issue_en && (issue_addr == AW'(gi));
        assign clr_hit = en && wr_en && (wr_addr == AW'(gi));
        assign pending_d[gi] = set_hit ? 1'b1 : (clr_hit ? 1'b0 : pending_q[gi]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    logic rs1_fwd;
    logic rs2_fwd;
    assign rs1_fwd  = (BYPASS != 0) && wr_en && (wr_addr == rs1_addr);
    assign rs2_fwd  = (BYPASS != 0) && wr_en && (wr_addr == rs2_addr);
    assign rs1_busy = en && pending_q[rs1_addr] && !rs1_fwd;
    assign rs2_busy = en && pending_q[rs2_addr] && !rs2_fwd;

endmodule

// File: rtl/pipe_reg_file.sv
// Register file for the pipelined core: async dual read, sync single write,
// optional write-to-read forwarding, and a one-entry-per-cycle clear sweep on reset.
module pipe_reg_file
    import rv_pkg::*;
#(
    parameter  int XLEN     = XLEN_DEF,
    parameter  int NREG     = 32,
    parameter  int BYPASS   = 1,
    parameter  int ZERO_REG = 1,
    localparam int AW       = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    output logic            init_done,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic            rs1_busy,
    output logic            rs2_busy,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic [XLEN-1:0] wr_data,
    input  logic            issue_en,
    input  logic [AW-1:0]   issue_addr
);

    rf_state_e       state_q, state_d;
    logic [AW-1:0]   clr_idx_q, clr_idx_d;
    logic            mem_we;
    logic [AW-1:0]   mem_waddr;
    logic [XLEN-1:0] mem_wdata;
    logic            ready;
    logic            wr_legal;

    // No parallel reset on the array so it can map onto RAM primitives.
    logic [XLEN-1:0] mem [NREG];

    assign ready     = (state_q == ST_READY);
    assign init_done = ready;
    assign wr_legal  = ready && wr_en &&
                       !((ZERO_REG != 0) && (wr_addr == AW'(REG_ZERO)));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_CLEAR;
            clr_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        mem_we    = 1'b0;
        mem_waddr = wr_addr;
        mem_wdata = wr_data;
        case (state_q)
            ST_CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = clr_idx_q;
                mem_wdata = '0;
                clr_idx_d = clr_idx_q + 1'b1;
                if (clr_idx_q == AW'(NREG - 1)) begin
                    state_d = ST_READY;
                end
            end
            ST_READY: begin
                mem_we = wr_legal;
            end
            default: begin
                state_d = ST_CLEAR;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    logic [AW-1:0]   rd_addr [2];
    logic [XLEN-1:0] rd_data [2];
    assign rd_addr[0] = rs1_addr;
    assign rd_addr[1] = rs2_addr;

    // Zero register first, then same-cycle forwarding, then the stored value.
    for (genvar gi = 0; gi < 2; gi++) begin : g_rd
        logic is_zero;
        logic fwd;
        assign is_zero = (ZERO_REG != 0) && (rd_addr[gi] == AW'(REG_ZERO));
        assign fwd     = (BYPASS != 0) && wr_legal && (wr_addr == rd_addr[gi]);
        assign rd_data[gi] = (!ready || is_zero) ? '0 :
                             (fwd ? wr_data : mem[rd_addr[gi]]);
    end

    assign rs1_data = rd_data[0];
    assign rs2_data = rd_data[1];

    reg_scoreboard #(
        .NREG     (NREG),
        .BYPASS   (BYPASS),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .en         (ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .issue_en   (issue_en),
        .issue_addr (issue_addr),
        .rs1_addr   (rs1_addr),
        .rs2_addr   (rs2_addr),
        .rs1_busy   (rs1_busy),
        .rs2_busy   (rs2_busy)
    );

endmodule

// File: tb/tb_pipe_reg_file.sv
// Directed bench for pipe_reg_file: one instance with forwarding (a_*) and one
// without (b_*), driven from the same inputs and checked against hand values.
module tb_pipe_reg_file;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic [AW-1:0]   rs1_addr, rs2_addr, wr_addr, issue_addr;
    logic            wr_en, issue_en;
    logic [XLEN-1:0] wr_data;

    logic            a_init_done, b_init_done;
    logic [XLEN-1:0] a_rs1_data, a_rs2_data, b_rs1_data, b_rs2_data;
    logic            a_rs1_busy, a_rs2_busy, b_rs1_busy, b_rs2_busy;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipe_reg_file #(.XLEN(XLEN), .NREG(NREG), .BYPASS(1), .ZERO_REG(1)) dut_a (
        .clk(clk), .rst(rst), .init_done(a_init_done),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(a_rs1_data), .rs2_data(a_rs2_data),
        .rs1_busy(a_rs1_busy), .rs2_busy(a_rs2_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .issue_en(issue_en), .issue_addr(issue_addr)
    );

    pipe_reg_file #(.XLEN(XLEN), .NREG(NREG), .BYPASS(0), .ZERO_REG(1)) dut_b (
        .clk(clk), .rst(rst), .init_done(b_init_done),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(b_rs1_data), .rs2_data(b_rs2_data),
        .rs1_busy(b_rs1_busy), .rs2_busy(b_rs2_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .issue_en(issue_en), .issue_addr(issue_addr)
    );

    // Inputs change 1 time unit after the rising edge; outputs are sampled 2 units after.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en = 1'b0; issue_en = 1'b0;
        wr_addr = '0; issue_addr = '0; wr_data = '0;
    endtask

    task automatic sweep_and_check(input string tag);
        for (int i = 1; i <= NREG; i++) begin
            tick();
            #1;
            n_vec++;
            if (a_init_done !== (i == NREG) || b_init_done !== (i == NREG)) begin
                n_err++;
                $display("FAIL %s_init_done edge %0d: a=%b b=%b expected %b",
                         tag, i, a_init_done, b_init_done, (i == NREG));
            end
            if (i < NREG) begin
                n_vec++;
                if (a_rs1_data !== '0 || a_rs1_busy !== 1'b0 || b_rs1_busy !== 1'b0) begin
                    n_err++;
                    $display("FAIL %s_gated edge %0d: rs1_data=%h busy=%b/%b expected 0",
                             tag, i, a_rs1_data, a_rs1_busy, b_rs1_busy);
                end
            end
        end
        idle();
        for (int r = 0; r < NREG; r++) begin
            rs1_addr = AW'(r);
            rs2_addr = AW'(NREG - 1 - r);
            #1;
            n_vec++;
            if (a_rs1_data !== '0 || a_rs2_data !== '0 || b_rs1_data !== '0 || b_rs2_data !== '0 ||
                a_rs1_busy || a_rs2_busy || b_rs1_busy || b_rs2_busy) begin
                n_err++;
                $display("FAIL %s_cleared x%0d: a=%h/%h b=%h/%h busy=%b%b%b%b expected 0",
                         tag, r, a_rs1_data, a_rs2_data, b_rs1_data, b_rs2_data,
                         a_rs1_busy, a_rs2_busy, b_rs1_busy, b_rs2_busy);
            end
        end
        $display("%s: sweep complete after %0d edges, all registers zero and idle", tag, NREG);
    endtask

    task automatic test_reset();
        idle();
        rs1_addr = 5'd5; rs2_addr = 5'd0;
        rst = 1'b1;
        repeat (3) tick();
        #1;
        n_vec++;
        if (a_init_done !== 1'b0 || b_init_done !== 1'b0) begin
            n_err++;
            $display("FAIL reset_init_done: a=%b b=%b expected 0", a_init_done, b_init_done);
        end
        rst = 1'b0;
        // Writes and issues during the sweep must be dropped.
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hFFFF_FFFF;
        issue_en = 1'b1; issue_addr = 5'd5;
        sweep_and_check("reset");
    endtask

    task automatic test_write_read();
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEAD_BEEF;
        tick();
        idle();
        rs1_addr = 5'd5;
        #1;
        n_vec++;
        if (a_rs1_data !== 32'hDEAD_BEEF || b_rs1_data !== 32'hDEAD_BEEF) begin
            n_err++;
            $display("FAIL write_x5: a=%h b=%h expected deadbeef", a_rs1_data, b_rs1_data);
        end
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h0000_1234; rs2_addr = 5'd0;
        #1;
        n_vec++;
        if (a_rs2_data !== '0 || b_rs2_data !== '0) begin
            n_err++;
            $display("FAIL write_x0_fwd: a=%h b=%h expected 0", a_rs2_data, b_rs2_data);
        end
        tick();
        idle();
        #1;
        n_vec++;
        if (a_rs2_data !== '0 || b_rs2_data !== '0) begin
            n_err++;
            $display("FAIL write_x0: a=%h b=%h expected 0", a_rs2_data, b_rs2_data);
        end
        $display("write_read: x5=%h x0=%h", a_rs1_data, a_rs2_data);
    endtask

    task automatic test_bypass();
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h1111_1111;
        tick();
        idle();
        issue_en = 1'b1; issue_addr = 5'd7;
        tick();
        idle();
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hA5A5_A5A5; rs1_addr = 5'd7;
        #1;
        n_vec++;
        if (a_rs1_data !== 32'hA5A5_A5A5 || a_rs1_busy !== 1'b0) begin
            n_err++;
            $display("FAIL bypass_on: data=%h busy=%b expected a5a5a5a5/0", a_rs1_data, a_rs1_busy);
        end
        n_vec++;
        if (b_rs1_data !== 32'h1111_1111 || b_rs1_busy !== 1'b1) begin
            n_err++;
            $display("FAIL bypass_off: data=%h busy=%b expected 11111111/1", b_rs1_data, b_rs1_busy);
        end
        tick();
        idle();
        #1;
        n_vec++;
        if (a_rs1_data !== 32'hA5A5_A5A5 || b_rs1_data !== 32'hA5A5_A5A5 || a_rs1_busy || b_rs1_busy) begin
            n_err++;
            $display("FAIL bypass_after: a=%h b=%h busy=%b/%b expected a5a5a5a5/0",
                     a_rs1_data, b_rs1_data, a_rs1_busy, b_rs1_busy);
        end
        $display("bypass: x7 fwd=%h nofwd=%h", 32'hA5A5_A5A5, 32'h1111_1111);
    endtask

    task automatic test_scoreboard();
        issue_en = 1'b1; issue_addr = 5'd3; rs2_addr = 5'd3;
        #1;
        n_vec++;
        if (a_rs2_busy !== 1'b0) begin
            n_err++;
            $display("FAIL sb_issue_cycle: busy=%b expected 0", a_rs2_busy);
        end
        tick();
        idle();
        #1;
        n_vec++;
        if (a_rs2_busy !== 1'b1 || b_rs2_busy !== 1'b1) begin
            n_err++;
            $display("FAIL sb_pending: busy=%b/%b expected 1/1", a_rs2_busy, b_rs2_busy);
        end
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h0000_0033;
        #1;
        n_vec++;
        if (a_rs2_busy !== 1'b0 || b_rs2_busy !== 1'b1) begin
            n_err++;
            $display("FAIL sb_write_cycle: busy=%b/%b expected 0/1", a_rs2_busy, b_rs2_busy);
        end
        tick();
        idle();
        #1;
        n_vec++;
        if (a_rs2_busy || b_rs2_busy || a_rs2_data !== 32'h33 || b_rs2_data !== 32'h33) begin
            n_err++;
            $display("FAIL sb_retired: busy=%b/%b data=%h/%h expected 0/0 33",
                     a_rs2_busy, b_rs2_busy, a_rs2_data, b_rs2_data);
        end
        $display("scoreboard: x3 issued, pending, retired with 00000033");
    endtask

    task automatic test_collision();
        issue_en = 1'b1; issue_addr = 5'd9;
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h0000_0099;
        tick();
        idle();
        rs1_addr = 5'd9;
        #1;
        n_vec++;
        if (a_rs1_busy !== 1'b1 || b_rs1_busy !== 1'b1 || a_rs1_data !== 32'h99) begin
            n_err++;
            $display("FAIL collide_set_wins: busy=%b/%b data=%h expected 1/1 99",
                     a_rs1_busy, b_rs1_busy, a_rs1_data);
        end
        issue_en = 1'b1; issue_addr = 5'd0;
        tick();
        idle();
        rs1_addr = 5'd0;
        #1;
        n_vec++;
        if (a_rs1_busy || b_rs1_busy || a_rs1_data !== '0) begin
            n_err++;
            $display("FAIL issue_x0: busy=%b/%b data=%h expected 0/0 0", a_rs1_busy, b_rs1_busy, a_rs1_data);
        end
        issue_en = 1'b1; issue_addr = 5'd10;
        wr_en = 1'b1; wr_addr = 5'd11; wr_data = 32'hCAFE_0011;
        tick();
        idle();
        rs1_addr = 5'd10; rs2_addr = 5'd11;
        #1;
        n_vec++;
        if (a_rs1_busy !== 1'b1 || b_rs1_busy !== 1'b1 || a_rs2_busy || b_rs2_busy ||
            b_rs2_data !== 32'hCAFE_0011) begin
            n_err++;
            $display("FAIL split_set_clr: busy10=%b/%b busy11=%b/%b x11=%h expected 1/1 0/0 cafe0011",
                     a_rs1_busy, b_rs1_busy, a_rs2_busy, b_rs2_busy, b_rs2_data);
        end
        $display("collision: x9 stays pending, x0 never pending, x10/x11 independent");
    endtask

    task automatic test_back_to_back();
        for (int i = 1; i <= 4; i++) begin
            wr_en = 1'b1; wr_addr = AW'(i + 15); wr_data = 32'h1000_0000 * i + i;
            tick();
        end
        idle();
        for (int i = 1; i <= 4; i++) begin
            rs1_addr = AW'(i + 15); rs2_addr = AW'(i + 15);
            #1;
            n_vec++;
            if (a_rs1_data !== (32'h1000_0000 * i + i) || b_rs2_data !== (32'h1000_0000 * i + i)) begin
                n_err++;
                $display("FAIL b2b_x%0d: a=%h b=%h expected %h", i + 15, a_rs1_data, b_rs2_data,
                         32'h1000_0000 * i + i);
            end
        end
        $display("back_to_back: x16..x19 written on consecutive cycles");
    endtask

    task automatic test_mid_sweep_reset();
        issue_en = 1'b1; issue_addr = 5'd12;
        tick();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (10) tick();
        #1;
        n_vec++;
        if (a_init_done !== 1'b0) begin
            n_err++;
            $display("FAIL midsweep_pre: init_done=%b expected 0", a_init_done);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sweep_and_check("midsweep");
    endtask

    initial begin
        rst = 1'b1;
        rs1_addr = '0; rs2_addr = '0;
        idle();
        test_reset();
        test_write_read();
        test_bypass();
        test_scoreboard();
        test_collision();
        test_back_to_back();
        test_mid_sweep_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
